seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/t_decoder.sv | 13 +
 rtl/seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the instruction sequencer.
//   state_e    - FSM state encodings (also driven out on phase)
//   OP_*       - opcode field constants IR[14:12]
//   final_step - last T-step of EXECUTE for a given opcode
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_INDIRECT  = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_INTERRUPT = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    function automatic logic [2:0] final_step(input logic [2:0] op);
        logic [2:0] t;
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_BSA: t = 3'd5;
            OP_STA, OP_BUN:                 t = 3'd4;
            OP_ISZ:                         t = 3'd6;
            default:                        t = 3'd3;   // OP_REG
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_decoder.sv
// t_decoder: one-hot decode of the sequence-counter value.
//   sc     - sequence-counter value (T-step index)
//   onehot - 1 << sc
module t_decoder #(
    parameter int W = 3
) (
    input  logic [W-1:0] sc,
    output logic [7:0]   onehot
);

    assign onehot = 8'd1 << sc;

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction-cycle sequencer (fetch / decode / indirect /
// execute / interrupt / halt) driven by an external T-step counter.
//   clk, rst        - clock, async active-low reset
//   sc_count        - current T-step from the sequence counter
//   sc_clr          - clears the sequence counter for the next cycle
//   ir_op/ir_i/ir_hlt - instruction fields, valid from T2
//   ien, int_req    - interrupt enable / request
//   t_onehot, phase - decoded T-step, current state
//   strobes         - ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem,
//                     exec_en, int_ack, halted, seq_err
//
// state     | meaning
// ----------+-------------------------------------------------
// FETCH     | T0 AR<-PC, T1 IR<-M[AR], PC++
// DECODE    | T2 latch IR fields, AR<-IR address
// INDIRECT  | T3 AR<-M[AR]
// EXECUTE   | opcode-dependent steps up to final_step(op)
// INTERRUPT | T2 acknowledge, PC++, clear R
// HALT      | counter held clear until reset
module seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int SC_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SC_W-1:0] sc_count,
    output logic            sc_clr,
    input  logic [2:0]      ir_op,
    input  logic            ir_i,
    input  logic            ir_hlt,
    input  logic            ien,
    input  logic            int_req,
    output logic [7:0]      t_onehot,
    output logic [2:0]      phase,
    output logic            ar_ld_pc,
    output logic            ir_ld,
    output logic            pc_inc,
    output logic            ar_ld_ir,
    output logic            ar_ld_mem,
    output logic            exec_en,
    output logic            int_ack,
    output logic            halted,
    output logic            seq_err
);

    state_e            state_q, state_d;
    logic              r_q, r_d;
    logic [2:0]        op_q, op_d;
    logic              i_q, i_d;
    logic              hlt_q, hlt_d;
    logic [SC_W-1:0]   cnt_q, cnt_d;
    logic              clr_q, clr_d;
    logic              vld_q, vld_d;
    logic              seq_err_q, seq_err_d;

    logic clr_c, pc_c, irl_c, inc_c, ari_c, mem_c, ex_c, ack_c, hlt_c;
    logic r_set, r_clr, seq_bad;

    t_decoder #(.W(SC_W)) u_t_decoder (
        .sc     (sc_count),
        .onehot (t_onehot)
    );

    // Counter must step by exactly one unless we cleared it last cycle;
    // the first cycle after reset has no history and is not checked.
    assign seq_bad = vld_q && !clr_q &&
                     ((cnt_q == {SC_W{1'b1}}) || (sc_count != cnt_q + SC_W'(1)));

    assign r_set = (sc_count > SC_W'(2)) && ien && int_req &&
                   (state_q != ST_INTERRUPT) && (state_q != ST_HALT);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        i_d       = i_q;
        hlt_d     = hlt_q;
        r_clr     = 1'b0;
        clr_c     = 1'b0;
        pc_c      = 1'b0;
        irl_c     = 1'b0;
        inc_c     = 1'b0;
        ari_c     = 1'b0;
        mem_c     = 1'b0;
        ex_c      = 1'b0;
        ack_c     = 1'b0;
        hlt_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (sc_count == SC_W'(0)) pc_c = 1'b1;
                if (sc_count == SC_W'(1)) begin
                    irl_c   = 1'b1;
                    inc_c   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (sc_count == SC_W'(2)) begin
                    ari_c   = 1'b1;
                    op_d    = ir_op;
                    i_d     = ir_i;
                    hlt_d   = ir_hlt;
                    state_d = (ir_op != OP_REG && ir_i) ? ST_INDIRECT : ST_EXECUTE;
                end
            end
            ST_INDIRECT: begin
                if (sc_count == SC_W'(3)) begin
                    mem_c   = i_q;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                ex_c = 1'b1;
                if (sc_count == SC_W'(final_step(op_q))) begin
                    clr_c = 1'b1;
                    if (op_q == OP_REG && hlt_q)
                        state_d = ST_HALT;
                    else if (r_q || r_set)   // a request landing on the last step still wins
                        state_d = ST_INTERRUPT;
                    else
                        state_d = ST_FETCH;
                end
            end
            ST_INTERRUPT: begin
                if (sc_count == SC_W'(2)) begin
                    inc_c   = 1'b1;
                    ack_c   = 1'b1;
                    clr_c   = 1'b1;
                    r_clr   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                clr_c = 1'b1;
                hlt_c = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        if (seq_bad) begin
            clr_c   = 1'b1;
            state_d = ST_FETCH;
        end

        r_d       = r_set | (r_q & ~r_clr);
        seq_err_d = seq_err_q | seq_bad;
        cnt_d     = sc_count;
        clr_d     = clr_c;
        vld_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            r_q       <= 1'b0;
            op_q      <= 3'd0;
            i_q       <= 1'b0;
            hlt_q     <= 1'b0;
            cnt_q     <= '0;
            clr_q     <= 1'b0;
            vld_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            op_q      <= op_d;
            i_q       <= i_d;
            hlt_q     <= hlt_d;
            cnt_q     <= cnt_d;
            clr_q     <= clr_d;
            vld_q     <= vld_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Strobes are decoded combinationally and must drop the instant reset asserts.
    assign sc_clr    = rst & clr_c;
    assign ar_ld_pc  = rst & pc_c;
    assign ir_ld     = rst & irl_c;
    assign pc_inc    = rst & inc_c;
    assign ar_ld_ir  = rst & ari_c;
    assign ar_ld_mem = rst & mem_c;
    assign exec_en   = rst & ex_c;
    assign int_ack   = rst & ack_c;
    assign halted    = rst & hlt_c;
    assign seq_err   = seq_err_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scripted T-step stimulus with a scoreboard of expected
// phase/strobe vectors, compared on the falling edge of each cycle.
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sc_count;
    logic       sc_clr;
    logic [2:0] ir_op;
    logic       ir_i, ir_hlt, ien, int_req;
    logic [7:0] t_onehot;
    logic [2:0] phase;
    logic       ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem;
    logic       exec_en, int_ack, halted, seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [9:0] M_CLR = 10'h200, M_PC  = 10'h100, M_IRL = 10'h080,
                           M_INC = 10'h040, M_ARI = 10'h020, M_MEM = 10'h010,
                           M_EX  = 10'h008, M_ACK = 10'h004, M_HLT = 10'h002,
                           M_ERR = 10'h001;

    typedef struct {
        string      tag;
        logic [15:0] v;
        logic [2:0] c;
        bit         oh;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    seq_ctrl #(.SC_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sc_count  (sc_count),
        .sc_clr    (sc_clr),
        .ir_op     (ir_op),
        .ir_i      (ir_i),
        .ir_hlt    (ir_hlt),
        .ien       (ien),
        .int_req   (int_req),
        .t_onehot  (t_onehot),
        .phase     (phase),
        .ar_ld_pc  (ar_ld_pc),
        .ir_ld     (ir_ld),
        .pc_inc    (pc_inc),
        .ar_ld_ir  (ar_ld_ir),
        .ar_ld_mem (ar_ld_mem),
        .exec_en   (exec_en),
        .int_ack   (int_ack),
        .halted    (halted),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {3'b000, phase, sc_clr, ar_ld_pc, ir_ld, pc_inc, ar_ld_ir,
                ar_ld_mem, exec_en, int_ack, halted, seq_err};
    endfunction

    function automatic logic [15:0] ev(input logic [2:0] ph, input logic [9:0] m);
        return {3'b000, ph, m};
    endfunction

    // Called at posedge+1: present T-step, queue what the cycle should show.
    task automatic step(input logic [2:0] c, input logic [2:0] ph,
                        input logic [9:0] m, input string tag);
        exp_t e;
        sc_count = c;
        e.tag = tag; e.v = ev(ph, m); e.c = c; e.oh = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic front(input string nm, input logic [9:0] err);
        step(3'd0, 3'd0, M_PC | err,          {nm, ".t0"});
        step(3'd1, 3'd0, M_IRL | M_INC | err, {nm, ".t1"});
        step(3'd2, 3'd1, M_ARI | err,         {nm, ".t2"});
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, obs(), mon_e.v);
            if (mon_e.oh)
                chk({mon_e.tag, ".oh"}, {8'h00, t_onehot}, {8'h00, 8'd1 << mon_e.c});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0; sc_count = 3'd0; ir_op = 3'd0; ir_i = 1'b0; ir_hlt = 1'b0;
        ien = 1'b0; int_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", obs(), 16'h0000);
        rst = 1'b1;

        // LDA direct
        ir_op = 3'd2; ir_i = 1'b0;
        front("lda", 10'h0);
        step(3'd3, 3'd3, M_EX,         "lda.t3");
        step(3'd4, 3'd3, M_EX,         "lda.t4");
        step(3'd5, 3'd3, M_EX | M_CLR, "lda.t5");

        // ISZ indirect
        ir_op = 3'd6; ir_i = 1'b1;
        front("isz", 10'h0);
        step(3'd3, 3'd2, M_MEM,        "isz.t3");
        step(3'd4, 3'd3, M_EX,         "isz.t4");
        step(3'd5, 3'd3, M_EX,         "isz.t5");
        step(3'd6, 3'd3, M_EX | M_CLR, "isz.t6");

        // ADD with interrupt request at T4
        ir_op = 3'd1; ir_i = 1'b0; ien = 1'b1;
        front("add", 10'h0);
        step(3'd3, 3'd3, M_EX, "add.t3");
        int_req = 1'b1;
        step(3'd4, 3'd3, M_EX, "add.t4");
        int_req = 1'b0;
        step(3'd5, 3'd3, M_EX | M_CLR, "add.t5");
        step(3'd0, 3'd4, 10'h0, "int.t0");
        step(3'd1, 3'd4, 10'h0, "int.t1");
        step(3'd2, 3'd4, M_INC | M_ACK | M_CLR, "int.t2");

        // Register-reference, no halt: R must be clear, so back to FETCH
        ir_op = 3'd7; ir_hlt = 1'b0;
        front("reg", 10'h0);
        step(3'd3, 3'd3, M_EX | M_CLR, "reg.t3");

        // STA with request on its final step: interrupt still taken
        ir_op = 3'd3;
        front("sta", 10'h0);
        step(3'd3, 3'd3, M_EX, "sta.t3");
        int_req = 1'b1;
        step(3'd4, 3'd3, M_EX | M_CLR, "sta.t4");
        int_req = 1'b0;
        step(3'd0, 3'd4, 10'h0, "int2.t0");
        step(3'd1, 3'd4, 10'h0, "int2.t1");
        step(3'd2, 3'd4, M_INC | M_ACK | M_CLR, "int2.t2");

        // BUN: request only during T0..T2 is ignored
        ir_op = 3'd4; int_req = 1'b1;
        front("bun", 10'h0);
        int_req = 1'b0;
        step(3'd3, 3'd3, M_EX,         "bun.t3");
        step(3'd4, 3'd3, M_EX | M_CLR, "bun.t4");

        // BSA: request with ien=0 is ignored
        ir_op = 3'd5; ien = 1'b0;
        front("bsa", 10'h0);
        int_req = 1'b1;
        step(3'd3, 3'd3, M_EX,         "bsa.t3");
        step(3'd4, 3'd3, M_EX,         "bsa.t4");
        step(3'd5, 3'd3, M_EX | M_CLR, "bsa.t5");
        int_req = 1'b0;

        // ISZ direct with the counter jumping 3 -> 5
        ir_op = 3'd6; ir_i = 1'b0;
        front("err", 10'h0);
        step(3'd3, 3'd3, M_EX,         "err.t3");
        step(3'd5, 3'd3, M_EX | M_CLR, "err.jump");

        // STA, reset asserted mid-T4 (seq_err sticky until then)
        ir_op = 3'd3;
        front("rsta", M_ERR);
        step(3'd3, 3'd3, M_EX | M_ERR, "rsta.t3");
        sc_count = 3'd4;
        #1 rst = 1'b0;
        #1 chk("rsta.now", obs(), 16'h0000);
        e.tag = "rsta.hold0"; e.v = 16'h0000; e.c = 3'd4; e.oh = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        sc_count = 3'd5;
        e.tag = "rsta.hold1"; e.c = 3'd5;
        sb.push_back(e);
        @(posedge clk); #1;

        // Release straight into an HLT instruction
        ir_op = 3'd7; ir_hlt = 1'b1; rst = 1'b1;
        front("hlt", 10'h0);
        step(3'd3, 3'd3, M_EX | M_CLR, "hlt.t3");
        ien = 1'b1; int_req = 1'b1;
        step(3'd0, 3'd5, M_CLR | M_HLT, "hlt.h0");
        step(3'd0, 3'd5, M_CLR | M_HLT, "hlt.h1");
        step(3'd4, 3'd5, M_CLR | M_HLT, "hlt.req4");
        step(3'd5, 3'd5, M_CLR | M_HLT, "hlt.req5");
        int_req = 1'b0; ien = 1'b0;

        rst = 1'b0;
        #1 chk("hlt.reset", obs(), 16'h0000);
        @(posedge clk); #1;
        ir_op = 3'd1; ir_hlt = 1'b0; rst = 1'b1;
        front("post", 10'h0);
        step(3'd3, 3'd3, M_EX,         "post.t3");
        step(3'd4, 3'd3, M_EX,         "post.t4");
        step(3'd5, 3'd3, M_EX | M_CLR, "post.t5");
        step(3'd0, 3'd0, M_PC,         "post.fetch");

        @(negedge clk);
        chk("sb.drain", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
